conv2d_row_engine: RTL and testbench
====================================

Name: conv2d_row_engine

Overview:
Computes one output row of a KxK 2-D convolution over a KERNEL_SIZE-row band streamed in column by column.
- LANES adjacent output positions are computed in parallel, sharing one kernel tap per cycle.
- Supports stride 1 or 2.
- Output is scaled, then saturated; results are written one per cycle to the destination scratchpad.
- Sits between the line-buffer column streamer and the activation scratchpad in the NPU convolution path.

Parameters:
DATA_W, 8, pixel width (unsigned)
KW_W, 8, kernel tap width (signed two's complement)
KERNEL_SIZE, 3, kernel edge K (K >= 2)
LANES, 2, parallel output positions (>= 1)
IMG_W, 28, input row width in columns
ACC_W, 24, signed accumulator width
SHIFT, 0, arithmetic right shift applied to accumulator before saturation
OUT_W, 8, signed result width
ADDR_W, 5, destination address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to process one output row; ignored unless idle
stride  in  2  1 or 2, sampled at accepted start; 0 or 3 treated as 1
in_dest_addr  in  ADDR_W  base destination address, sampled at accepted start
col_in  in  K*DATA_W  one image column; row 0 in the lowest DATA_W bits
col_valid  in  1  col_in valid
col_ready  out  1  engine accepts a column this cycle
kernel_addr  out  ceil(log2(K*K))  tap index, row-major t = r*K + c
kernel_in  in  KW_W  tap value; combinational read, valid in the same cycle as kernel_addr
dest_wr_en  out  1  write strobe
dest_addr  out  ADDR_W  write address
dest_data  out  OUT_W  write data
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE.
  - All outputs 0: col_ready, kernel_addr, dest_wr_en, dest_addr, dest_data, busy, done.
  - Accumulators and window registers cleared; any in-flight row is discarded with no further writes.
- Derived values:
  - N_OUT = (IMG_W-K)/stride + 1 output positions per row.
  - WIN = K + (LANES-1)*stride window columns.
  - Lane l uses window columns l*stride .. l*stride+K-1; column 0 is the oldest.
  - Columns consumed per row = K + (N_OUT-1)*stride. Any remaining columns are not requested.
- Column transfer: occurs when col_valid && col_ready. A new column shifts into the top of the window and the oldest column is dropped. col_ready is high only in FILL and ADV. col_valid low stalls without loss.
- States:
  - IDLE: on start, latch stride and base address -> FILL.
  - FILL: accept WIN columns, or fewer if the row needs fewer -> MAC.
  - MAC: exactly K*K cycles; kernel_addr steps 0..K*K-1.
    - Each cycle, every lane: acc_l += pixel(r,c) * kernel_in.
    - Operand widths: unsigned x signed, sign-extended to ACC_W, wraps modulo 2^ACC_W.
    - Accumulators are cleared on entry to MAC -> WRITE.
  - WRITE: one cycle per valid lane, lane 0 first.
    - dest_wr_en=1; dest_data = sat(acc_l >>> SHIFT); dest_addr = base + output index, wrapping mod 2^ADDR_W.
    - Lanes whose output index >= N_OUT are skipped (partial last group).
    - After the last output of the row -> DONE; otherwise -> ADV.
  - ADV: accept min(LANES*stride, columns remaining) new columns -> MAC.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Saturation (default): clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency with no stall, per group: MAC K*K + WRITE n_valid + ADV cycles. Throughput is LANES outputs per group.
- start while busy: ignored. stride and in_dest_addr changes after accept: no effect.
- col_valid while col_ready=0: no transfer, no error.

Optional Feature:
CONV_RELU_EN.
- Defined: after shift, negative results write 0; positive results saturate to 2^(OUT_W-1)-1.
- Undefined: signed saturation only, as above.
- Port list identical in both builds.

Test Plan:
1. Defaults, stride=1, all pixels 1, all taps 1, base 3 -> 26 writes of 9 at addresses 3..28, done pulses once, busy low afterwards.
2. stride=2, same data -> 13 writes of 9; last group writes lane 0 only; exactly 27 columns accepted.
3. Pixels 100, taps -1 -> acc -900. Default build: writes -128 (0x80). CONV_RELU_EN build: writes 0.
4. Ramp data (column index) with random col_valid gaps -> results identical to the gap-free run; no write occurs while in FILL or ADV.
5. rst_n low during MAC of group 4, then release and restart -> no writes after reset; all outputs 0 during reset; second run fully correct.
6. stride=3 input, with a second start pulsed mid-row -> behaves as stride 1; second start ignored; exactly 26 writes.

Source files
------------

// File: rtl/conv2d_row_engine_if.sv
// conv2d_row_engine_if: column stream, kernel tap read and destination write bus of the row engine.
//   col_in/col_valid/col_ready : one K-pixel image column per transfer, row 0 in the low bits
//   kernel_addr/kernel_in      : row-major tap index out, tap value back in the same cycle
//   dest_wr_en/dest_addr/dest_data : one saturated result per write strobe
//   modport master = engine side, modport slave = streamer/kernel store/scratchpad side
interface conv2d_row_engine_if #(
    parameter int DATA_W      = 8,
    parameter int KW_W        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int OUT_W       = 8,
    parameter int ADDR_W      = 5
);
    localparam int KA_W = $clog2(KERNEL_SIZE * KERNEL_SIZE);
    logic [KERNEL_SIZE*DATA_W-1:0] col_in;
    logic                          col_valid;
    logic                          col_ready;
    logic [KA_W-1:0]               kernel_addr;
    logic signed [KW_W-1:0]        kernel_in;
    logic                          dest_wr_en;
    logic [ADDR_W-1:0]             dest_addr;
    logic [OUT_W-1:0]              dest_data;
    modport master (
        input  col_in, col_valid, kernel_in,
        output col_ready, kernel_addr, dest_wr_en, dest_addr, dest_data
    );
    modport slave (
        output col_in, col_valid, kernel_in,
        input  col_ready, kernel_addr, dest_wr_en, dest_addr, dest_data
    );
endinterface

// File: rtl/conv2d_row_engine.sv
// conv2d_row_engine: one output row of a KxK convolution, LANES outputs per group, stride 1 or 2.
//   clk, rst_n (async active-low)
//   start, stride, in_dest_addr : row request, stride and base address latched when idle
//   busy, done                  : row in progress / one-cycle pulse after the last write
//   bus (master)                : column stream, kernel tap read, destination writes
//   Macro CONV_RELU_EN: when defined, negative results write 0 (ReLU) instead of signed saturation.
module conv2d_row_engine #(
    parameter int DATA_W      = 8,
    parameter int KW_W        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int LANES       = 2,
    parameter int IMG_W       = 28,
    parameter int ACC_W       = 24,
    parameter int SHIFT       = 0,
    parameter int OUT_W       = 8,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        stride,
    input  logic [ADDR_W-1:0] in_dest_addr,
    output logic              busy,
    output logic              done,
    conv2d_row_engine_if.master bus
);
    localparam int K    = KERNEL_SIZE;
    localparam int KK   = K * K;
    localparam int KA_W = $clog2(KK);
    localparam int WIN1 = K + (LANES - 1);
    localparam int WIN2 = K + 2 * (LANES - 1);
    localparam int WMAX = WIN2;
    localparam int N1   = (IMG_W - K) + 1;
    localparam int N2   = (IMG_W - K) / 2 + 1;
    localparam int C1   = K + (N1 - 1);
    localparam int C2   = K + (N2 - 1) * 2;
    localparam int CW   = $clog2(IMG_W + 4 * LANES + 1) + 1;
    localparam int IW   = $clog2(WMAX);
    localparam int RW   = $clog2(K);
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW   = DATA_W + 1 + KW_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [2:0] {IDLE, FILL, MAC, WRITE, ADV, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     s2_q, s2_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [CW-1:0]            col_cnt_q, col_cnt_d;
    logic [CW-1:0]            gs_q, gs_d;
    logic [CW-1:0]            ob_q, ob_d;
    logic [KA_W-1:0]          tap_q, tap_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  acc_d [LANES];
    logic [DATA_W-1:0]        win_q [WMAX][K];
    logic [DATA_W-1:0]        win_d [WMAX][K];

    int                       s_i, n_out, need, win_w, tgt, r_i, c_i, off, oi, p;
    logic [DATA_W-1:0]        px;
    logic signed [PW-1:0]     pw;
    logic signed [ACC_W-1:0]  sh;
    logic [OUT_W-1:0]         sat_v;

    always_comb begin
        state_d   = state_q;
        s2_d      = s2_q;
        base_d    = base_q;
        col_cnt_d = col_cnt_q;
        gs_d      = gs_q;
        ob_d      = ob_q;
        tap_d     = tap_q;
        lane_d    = lane_q;
        acc_d     = acc_q;
        win_d     = win_q;
        p         = 0;
        px        = '0;
        pw        = '0;
        bus.col_ready   = 1'b0;
        bus.kernel_addr = '0;
        bus.dest_wr_en  = 1'b0;
        bus.dest_addr   = '0;
        bus.dest_data   = '0;
        done  = 1'b0;
        busy  = (state_q == FILL) || (state_q == MAC) || (state_q == WRITE) || (state_q == ADV);
        s_i   = s2_q ? 2 : 1;
        n_out = s2_q ? N2 : N1;
        need  = s2_q ? C2 : C1;
        win_w = s2_q ? WIN2 : WIN1;
        // Column target for the current group: its full window, capped at the row's last column.
        tgt   = (int'(gs_q) + win_w < need) ? int'(gs_q) + win_w : need;
        r_i   = int'(tap_q) / K;
        c_i   = int'(tap_q) % K;
        // Physical slot of the group's first window column; the newest column sits at WMAX-1,
        // so a short final ADV simply leaves the window shifted less and this offset absorbs it.
        off   = WMAX + int'(gs_q) - int'(col_cnt_q);
        oi    = int'(ob_q) + int'(lane_q);
        sh    = acc_q[lane_q] >>> SHIFT;
`ifdef CONV_RELU_EN
        sat_v = (sh < 0) ? '0 : (sh > SAT_HI) ? OUT_W'(SAT_HI) : OUT_W'(sh);
`else
        sat_v = (sh > SAT_HI) ? OUT_W'(SAT_HI) : (sh < SAT_LO) ? OUT_W'(SAT_LO) : OUT_W'(sh);
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    s2_d      = (stride == 2'd2);
                    base_d    = in_dest_addr;
                    col_cnt_d = '0;
                    gs_d      = '0;
                    ob_d      = '0;
                    state_d   = FILL;
                end
            end
            FILL, ADV: begin
                bus.col_ready = 1'b1;
                if (bus.col_valid) begin
                    for (int i = 0; i < WMAX - 1; i++) win_d[i] = win_q[i+1];
                    for (int r = 0; r < K; r++) win_d[WMAX-1][r] = bus.col_in[r*DATA_W +: DATA_W];
                    col_cnt_d = col_cnt_q + CW'(1);
                    if (int'(col_cnt_q) + 1 >= tgt) begin
                        state_d = MAC;
                        tap_d   = '0;
                        for (int l = 0; l < LANES; l++) acc_d[l] = '0;
                    end
                end
            end
            MAC: begin
                bus.kernel_addr = tap_q;
                for (int l = 0; l < LANES; l++) begin
                    p  = off + l * s_i + c_i;
                    // Lanes past the end of the row may point beyond the window; feed them zero.
                    px = (p >= 0 && p < WMAX) ? win_q[IW'(p)][RW'(r_i)] : '0;
                    pw = $signed({1'b0, px}) * bus.kernel_in;
                    acc_d[l] = acc_q[l] + ACC_W'(pw);
                end
                tap_d = tap_q + KA_W'(1);
                if (tap_q == KA_W'(KK - 1)) begin
                    state_d = WRITE;
                    lane_d  = '0;
                end
            end
            WRITE: begin
                bus.dest_wr_en = 1'b1;
                bus.dest_addr  = base_q + ADDR_W'(oi);
                bus.dest_data  = sat_v;
                if (oi + 1 >= n_out) state_d = DONE;
                else if (int'(lane_q) == LANES - 1) begin
                    state_d = ADV;
                    ob_d    = ob_q + CW'(LANES);
                    gs_d    = gs_q + CW'(LANES * s_i);
                end
                else lane_d = lane_q + LW'(1);
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s2_q      <= 1'b0;
            base_q    <= '0;
            col_cnt_q <= '0;
            gs_q      <= '0;
            ob_q      <= '0;
            tap_q     <= '0;
            lane_q    <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            for (int i = 0; i < WMAX; i++)
                for (int r = 0; r < K; r++) win_q[i][r] <= '0;
        end else begin
            state_q   <= state_d;
            s2_q      <= s2_d;
            base_q    <= base_d;
            col_cnt_q <= col_cnt_d;
            gs_q      <= gs_d;
            ob_q      <= ob_d;
            tap_q     <= tap_d;
            lane_q    <= lane_d;
            acc_q     <= acc_d;
            win_q     <= win_d;
        end
    end
endmodule

// File: tb/tb_conv2d_row_engine.sv
// tb_conv2d_row_engine: scoreboard bench for conv2d_row_engine with directed rows.
module tb_conv2d_row_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] stride;
    logic [4:0] in_dest_addr;
    logic       busy, done;

    conv2d_row_engine_if #(.DATA_W(8), .KW_W(8), .KERNEL_SIZE(3), .OUT_W(8), .ADDR_W(5)) bus ();

    conv2d_row_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride),
        .in_dest_addr(in_dest_addr), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic signed [7:0] kern [16];
    assign bus.kernel_in = kern[bus.kernel_addr];

    typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q [$];
    int  checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0, cols_acc = 0;
    bit  pmode = 0, gaps = 0, stop_drv = 0;
    int  pval = 1;

    function automatic logic [7:0] pix(int r, int c);
        return pmode ? 8'(c + 10 * r) : 8'(pval);
    endfunction

    function automatic logic [7:0] model(int o, int s);
        int acc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc += int'(pix(r, o * s + c)) * int'(kern[r*3+c]);
`ifdef CONV_RELU_EN
        if (acc < 0) return 8'h00;
`else
        if (acc < -128) return 8'h80;
`endif
        if (acc > 127) return 8'h7f;
        return 8'(acc);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (bus.dest_wr_en) begin
                wr_cnt++;
                check("write_while_col_ready", int'(bus.col_ready), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                             bus.dest_addr, bus.dest_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", int'(bus.dest_addr), int'(e.a));
                    check("wr_data", int'(bus.dest_data), int'(e.d));
                end
            end
        end
    end

    task automatic drive_cols();
        int cidx = 0;
        bit took;
        while (!stop_drv) begin
            bus.col_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int r = 0; r < 3; r++) bus.col_in[r*8 +: 8] = pix(r, cidx);
            @(negedge clk);
            took = bus.col_valid && bus.col_ready;
            @(posedge clk);
            #1;
            if (took) begin
                cidx++;
                cols_acc++;
            end
        end
        bus.col_valid = 1'b0;
    endtask

    task automatic pulse_start(input int st, input int base);
        @(posedge clk);
        #1;
        start = 1'b1;
        stride = 2'(st);
        in_dest_addr = 5'(base);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_row(input int st, input int base);
        int s = (st == 2) ? 2 : 1;
        int n = (28 - 3) / s + 1;
        wr_t e;
        for (int o = 0; o < n; o++) begin
            e.a = 5'(base + o);
            e.d = model(o, s);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_row(input int st, input int base, input bit g, input int exp_cols, input bit restart);
        int t = 0;
        push_row(st, base);
        done_cnt = 0;
        cols_acc = 0;
        gaps = g;
        stop_drv = 0;
        pulse_start(st, base);
        fork drive_cols(); join_none
        if (restart)
            fork
                begin
                    repeat (40) @(posedge clk);
                    #1;
                    start = 1'b1;
                    stride = 2'd2;
                    in_dest_addr = 5'd0;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            join_none
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", int'(done), 1);
        stop_drv = 1;
        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", int'(busy), 0);
        check("cols_accepted", cols_acc, exp_cols);
        exp_q.delete();
    endtask

    task automatic set_kern(input int v);
        for (int i = 0; i < 16; i++) kern[i] = (i < 9) ? 8'(v) : 8'sd0;
    endtask

    initial begin
        int w0, t;
        rst_n = 1'b0;
        start = 1'b0;
        stride = 2'd1;
        in_dest_addr = '0;
        bus.col_valid = 1'b0;
        bus.col_in = '0;
        set_kern(1);
        #12;
        check("reset_outputs", int'({busy, done, bus.col_ready, bus.kernel_addr, bus.dest_wr_en,
                                     bus.dest_addr, bus.dest_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        pmode = 0; pval = 1; set_kern(1);
        run_row(1, 3, 0, 28, 0);
        run_row(2, 0, 0, 27, 0);

        pval = 100; set_kern(-1);
        run_row(1, 0, 0, 28, 0);

        pmode = 1;
        kern[0] = 1; kern[1] = -2; kern[2] = 3; kern[3] = 0; kern[4] = 1;
        kern[5] = -1; kern[6] = 2; kern[7] = 0; kern[8] = -3;
        run_row(1, 7, 0, 28, 0);
        run_row(1, 7, 1, 28, 0);
        run_row(2, 20, 1, 27, 0);

        push_row(1, 0);
        cols_acc = 0;
        gaps = 0;
        stop_drv = 0;
        w0 = wr_cnt;
        pulse_start(1, 0);
        fork drive_cols(); join_none
        t = 0;
        while (wr_cnt - w0 < 6 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (bus.kernel_addr != 4'd4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mac_tap_reached", int'(bus.kernel_addr), 4);
        #2;
        rst_n = 1'b0;
        stop_drv = 1;
        exp_q.delete();
        #1;
        check("writes_before_reset", wr_cnt - w0, 6);
        check("reset_outputs_mid", int'({busy, done, bus.col_ready, bus.kernel_addr, bus.dest_wr_en,
                                         bus.dest_addr, bus.dest_data}), 0);
        repeat (4) @(negedge clk);
        check("reset_outputs_hold", int'({busy, done, bus.col_ready, bus.kernel_addr, bus.dest_wr_en,
                                          bus.dest_addr, bus.dest_data}), 0);
        rst_n = 1'b1;
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        check("no_writes_after_reset", wr_cnt - w0, 0);
        check("idle_after_reset", int'(busy), 0);
        run_row(1, 0, 0, 28, 0);

        pmode = 0; pval = 1; set_kern(1);
        run_row(3, 5, 0, 28, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
